psram_arbiter: RTL

Two-port arbiter and sequencer in front of the PSRAM memory controller. It shares the single controller between the CPU (6510 bus, read/write) and the VIC-II (read-only fetches). The PHI0 phase decides which requester is preferred, and a starvation limit keeps either side from being locked out. It turns each granted request into one controller transaction (start pulse, busy handshake) and returns the data with a one-cycle acknowledge.

---
 rtl/psram_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/psram_arbiter.sv
// psram_arbiter
//   Shares one PSRAM controller between the CPU (read/write) and the VIC-II
//   (read-only). PHI0 picks the preferred side in IDLE, a per-requester wait
//   counter forces a win after MAX_WAIT contested losses, and the side just
//   served is masked for one IDLE cycle so a synchronous master can drop req.
//   Each grant becomes one controller transaction: mem_ce pulse, wait for
//   mem_busy to rise (with timeout), wait for it to fall, then a one-cycle ack.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   phase               PHI0 level: 0 = VIC preferred, 1 = CPU preferred
//   cpu_req/write/addr/wdata -> cpu_ack, cpu_rdata
//   vic_req/addr             -> vic_ack, vic_rdata
//   mem_ce/write/addr/wdata  -> controller; mem_busy, mem_rdata <- controller
//   err                 sticky start-timeout flag
//   dbg_state           current FSM state (IDLE=0 ISSUE=1 WAIT_START=2
//                       WAIT_DONE=3 RESP=4)
//
// Handshake: a requester raises req (level) and holds it until its ack
// pulses for one cycle; rdata is valid in that ack cycle. Dropping req after
// the grant does not cancel the transaction.
module psram_arbiter #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 8,
    parameter int MAX_WAIT      = 3,
    parameter int START_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              phase,
    input  logic              cpu_req,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vic_req,
    input  logic [ADDR_W-1:0] vic_addr,
    output logic              vic_ack,
    output logic [DATA_W-1:0] vic_rdata,
    output logic              mem_ce,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_busy,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err,
    output logic [2:0]        dbg_state
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int TW = $clog2(START_TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
    localparam logic [TW-1:0] TO_LAST  = TW'(START_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ISSUE      = 3'd1,
        S_WAIT_START = 3'd2,
        S_WAIT_DONE  = 3'd3,
        S_RESP       = 3'd4
    } state_t;

    state_t          state, state_next;
    logic            owner_vic;
    logic            hold_cpu, hold_vic;
    logic [WW-1:0]   cpu_wait, vic_wait;
    logic [TW-1:0]   tcnt;

    logic            cpu_ok, vic_ok;
    logic            contested, grant_cpu, grant_vic;
    logic            timeout_hit, done_hit;

    assign dbg_state = state;
    assign cpu_ok    = cpu_req & ~hold_cpu;
    assign vic_ok    = vic_req & ~hold_vic;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        contested   = 1'b0;
        grant_cpu   = 1'b0;
        grant_vic   = 1'b0;
        timeout_hit = 1'b0;
        done_hit    = 1'b0;
        case (state)
            S_IDLE: begin
                if (cpu_ok && vic_ok) begin
                    contested = 1'b1;
                    // The non-preferred side wins once it has lost MAX_WAIT times.
                    if (phase) begin
                        grant_vic = (vic_wait == WAIT_MAX);
                        grant_cpu = ~grant_vic;
                    end else begin
                        grant_cpu = (cpu_wait == WAIT_MAX);
                        grant_vic = ~grant_cpu;
                    end
                end else begin
                    grant_cpu = cpu_ok;
                    grant_vic = vic_ok;
                end
                if (grant_cpu || grant_vic) state_next = S_ISSUE;
            end
            S_ISSUE: state_next = S_WAIT_START;
            S_WAIT_START: begin
                if (mem_busy) begin
                    state_next = S_WAIT_DONE;
                end else if (tcnt == TO_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = S_RESP;
                end
            end
            S_WAIT_DONE: begin
                if (!mem_busy) begin
                    done_hit   = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_vic <= 1'b0;
            hold_cpu  <= 1'b0;
            hold_vic  <= 1'b0;
            cpu_wait  <= '0;
            vic_wait  <= '0;
            tcnt      <= '0;
            mem_ce    <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_ack   <= 1'b0;
            vic_ack   <= 1'b0;
            cpu_rdata <= '0;
            vic_rdata <= '0;
            err       <= 1'b0;
        end else begin
            // Pulses are registered copies of the upcoming state.
            mem_ce  <= (state_next == S_ISSUE);
            cpu_ack <= (state_next == S_RESP) && !owner_vic;
            vic_ack <= (state_next == S_RESP) &&  owner_vic;
            // Mask the side being served for the single IDLE cycle after RESP.
            hold_cpu <= (state == S_RESP) && !owner_vic;
            hold_vic <= (state == S_RESP) &&  owner_vic;

            if (grant_cpu) begin
                owner_vic <= 1'b0;
                mem_addr  <= cpu_addr;
                mem_write <= cpu_write;
                mem_wdata <= cpu_wdata;
                cpu_wait  <= '0;
                if (contested && vic_wait != WAIT_MAX) vic_wait <= vic_wait + 1'b1;
            end
            if (grant_vic) begin
                owner_vic <= 1'b1;
                mem_addr  <= vic_addr;
                mem_write <= 1'b0;
                mem_wdata <= '0;
                vic_wait  <= '0;
                if (contested && cpu_wait != WAIT_MAX) cpu_wait <= cpu_wait + 1'b1;
            end

            if (state == S_ISSUE)           tcnt <= '0;
            else if (state == S_WAIT_START) tcnt <= tcnt + 1'b1;

            if (timeout_hit) begin
                err <= 1'b1;
                if (owner_vic) vic_rdata <= '1;
                else           cpu_rdata <= '1;
            end
            if (done_hit && !mem_write) begin
                if (owner_vic) vic_rdata <= mem_rdata;
                else           cpu_rdata <= mem_rdata;
            end
        end
    end

endmodule
